// File: rtl/mac_pkg.sv
// Shared definitions for the MAC instruction initiator: opcodes, sequencer
// states and the accumulator guard-bit check.
package mac_pkg;

    localparam logic [2:0] MAC_CLR = 3'b000;
    localparam logic [2:0] MAC_MUL = 3'b001;
    localparam logic [2:0] MAC_ACC = 3'b010;
    localparam logic [2:0] MAC_SAT = 3'b011;

    localparam int MAC_RES_W = 40;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        SAT   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Guard bits disagree with the sign of the 32-bit result: value left the 32-bit range.
    function automatic logic guard_ovf(input logic [7:0] protect, input logic [31:0] result);
        return protect != {8{result[31]}};
    endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Streams operand pairs of a dot-product command into the MAC as a
// CLR/MUL/MAC/SAT sequence and returns the captured accumulator.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int MAC_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 cmd_sat,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [15:0]          op_a,
    input  logic [15:0]          op_b,
    output logic [2:0]           mac_instruction,
    output logic [15:0]          mac_multiplier,
    output logic [15:0]          mac_multiplicand,
    output logic                 mac_stall,
    input  logic [31:0]          mac_result,
    input  logic [7:0]           mac_protect,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MAC_RES_W-1:0] res_data,
    output logic                 res_ovf,
    output logic                 busy
);

    localparam int DRN_W = $clog2(MAC_LATENCY);

    seq_state_t           state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [DRN_W-1:0]     drn_q, drn_d;
    logic                 sat_q, sat_d;
    logic                 first_q, first_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 op_ready_q, op_ready_d;
    logic [2:0]           instr_q, instr_d;
    logic [15:0]          mult_q, mult_d;
    logic [15:0]          mcand_q, mcand_d;
    logic                 stall_q, stall_d;
    logic                 res_valid_q, res_valid_d;
    logic [MAC_RES_W-1:0] res_data_q, res_data_d;
    logic                 res_ovf_q, res_ovf_d;
    logic                 busy_q, busy_d;

    // Next-state and next-output decode; outputs describe the instruction launched at the coming edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drn_d       = drn_q;
        sat_d       = sat_q;
        first_d     = first_q;
        instr_d     = MAC_CLR;
        mult_d      = 16'h0000;
        mcand_d     = 16'h0000;
        stall_d     = 1'b1;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            IDLE: begin
                stall_d = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    cnt_d   = cmd_len;
                    sat_d   = cmd_sat;
                    first_d = 1'b0;
                    drn_d   = DRN_W'(MAC_LATENCY - 1);
                    if (cmd_len == {LEN_W{1'b0}}) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (op_valid && op_ready_q) begin
                    instr_d = first_q ? MAC_ACC : MAC_MUL;
                    mult_d  = op_a;
                    mcand_d = op_b;
                    stall_d = 1'b0;
                    first_d = 1'b1;
                    if (cnt_q != {LEN_W{1'b0}}) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (cnt_q <= LEN_W'(1)) begin
                        state_d = sat_q ? SAT : DRAIN;
                        drn_d   = DRN_W'(MAC_LATENCY - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    // Bubble: CLR before the first pair, add-zero after it, so the sum is untouched.
                    instr_d = first_q ? MAC_ACC : MAC_CLR;
                    stall_d = 1'b1;
                end
            end
            SAT: begin
                instr_d = MAC_SAT;
                stall_d = 1'b0;
                state_d = DRAIN;
                drn_d   = DRN_W'(MAC_LATENCY - 1);
            end
            DRAIN: begin
                if (drn_q == {DRN_W{1'b0}}) begin
                    res_data_d  = {mac_protect, mac_result};
                    res_ovf_d   = guard_ovf(mac_protect, mac_result);
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        op_ready_d  = (state_d == RUN);
        busy_d      = (state_d != IDLE);
    end

    // State, counters and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= {LEN_W{1'b0}};
            drn_q       <= {DRN_W{1'b0}};
            sat_q       <= 1'b0;
            first_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            op_ready_q  <= 1'b0;
            instr_q     <= MAC_CLR;
            mult_q      <= 16'h0000;
            mcand_q     <= 16'h0000;
            stall_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {MAC_RES_W{1'b0}};
            res_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drn_q       <= drn_d;
            sat_q       <= sat_d;
            first_q     <= first_d;
            cmd_ready_q <= cmd_ready_d;
            op_ready_q  <= op_ready_d;
            instr_q     <= instr_d;
            mult_q      <= mult_d;
            mcand_q     <= mcand_d;
            stall_q     <= stall_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign op_ready         = op_ready_q;
    assign mac_instruction  = instr_q;
    assign mac_multiplier   = mult_q;
    assign mac_multiplicand = mcand_q;
    assign mac_stall        = stall_q;
    assign res_valid        = res_valid_q;
    assign res_data         = res_data_q;
    assign res_ovf          = res_ovf_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC, dot-product reference model,
// scoreboard with an independent negedge monitor.
module tb_mac_sequencer;
    import mac_pkg::*;

    localparam int LEN_W = 8;
    localparam int LAT   = 2;

    logic clk, reset_n;
    logic cmd_valid, cmd_ready, cmd_sat;
    logic [LEN_W-1:0] cmd_len;
    logic op_valid, op_ready;
    logic [15:0] op_a, op_b, mac_multiplier, mac_multiplicand;
    logic [2:0] mac_instruction;
    logic mac_stall;
    logic [31:0] mac_result;
    logic [7:0] mac_protect;
    logic res_valid, res_ready, res_ovf, busy;
    logic [39:0] res_data;

    mac_sequencer #(.LEN_W(LEN_W), .MAC_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_sat(cmd_sat),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_instruction(mac_instruction), .mac_multiplier(mac_multiplier),
        .mac_multiplicand(mac_multiplicand), .mac_stall(mac_stall),
        .mac_result(mac_result), .mac_protect(mac_protect),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .busy(busy)
    );

    typedef struct {
        logic [39:0] data;
        logic        ovf;
        int          len;
        int          bub;
    } exp_t;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;
    exp_t sb[$];
    int cur_a[$], cur_b[$], cur_gap[$];
    longint acc_edge, hs_edge;
    longint acc;
    logic [39:0] hist [LAT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=no_end required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic abort_run(input string name);
        check(name, 64'd0, 64'd1);
        finish_run();
    endtask

    // Behavioural MAC: the result of the instruction launched at edge t is presented for edge t+LAT.
    initial begin
        acc = 0;
        for (int k = 0; k < LAT; k++) hist[k] = 40'd0;
        mac_result = 32'd0;
        mac_protect = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                acc = 0;
                for (int k = 0; k < LAT; k++) hist[k] = 40'd0;
            end else begin
                longint p;
                p = longint'($signed(mac_multiplier)) * longint'($signed(mac_multiplicand));
                case (mac_instruction)
                    MAC_CLR: acc = 0;
                    MAC_MUL: acc = p;
                    MAC_ACC: acc = acc + p;
                    MAC_SAT: begin
                        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
                        else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
                    end
                    default: acc = acc;
                endcase
                for (int k = LAT - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = acc[39:0];
            end
            {mac_protect, mac_result} = hist[LAT-1];
        end
    end

    // Monitor: checks every presented result against the scoreboard front.
    initial begin
        bit prev_v;
        bit m_sat;
        longint last_launch;
        int ops, bub;
        prev_v = 0; m_sat = 0; last_launch = 0; ops = 0; bub = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_v = 0; ops = 0; bub = 0;
            end else begin
                if (mac_stall)
                    check("stall_ops_zero",
                          {(mac_instruction == MAC_CLR) || (mac_instruction == MAC_ACC),
                           mac_multiplier, mac_multiplicand}, 64'h1_0000_0000);
                if (mac_stall && mac_instruction == MAC_ACC) bub++;
                if (cmd_valid && cmd_ready) begin
                    m_sat = cmd_sat;
                    if (cmd_len == 0) last_launch = cyc + 1;
                end
                if (op_valid && op_ready) begin
                    ops++;
                    last_launch = cyc + 1 + (m_sat ? 1 : 0);
                end
                if (res_valid) begin
                    check("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
                    if (!prev_v) check("result_latency", 64'(cyc - last_launch), 64'(LAT));
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'(res_valid), 64'd0);
                    end else begin
                        check("res_data", 64'(res_data), 64'(sb[0].data));
                        check("res_ovf", 64'(res_ovf), 64'(sb[0].ovf));
                        if (res_ready) begin
                            check("pairs_accepted", 64'(ops), 64'(sb[0].len));
                            check("bubble_add_zero", 64'(bub), 64'(sb[0].bub));
                            void'(sb.pop_front());
                            ops = 0; bub = 0;
                        end
                    end
                end
                prev_v = res_valid;
            end
        end
    end

    task automatic prep_random(input int n);
        cur_a.delete(); cur_b.delete(); cur_gap.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur_a.push_back(-32768);
                cur_b.push_back(-32768);
            end else begin
                cur_a.push_back(int'($urandom_range(0, 65535)) - 32768);
                cur_b.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            cur_gap.push_back($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0);
        end
    endtask

    // Reference: plain dot product, optionally clamped to the signed 32-bit range.
    task automatic issue_cmd(input bit sat);
        exp_t e;
        longint s;
        bit got;
        s = 0;
        e.bub = 0;
        for (int i = 0; i < cur_a.size(); i++) begin
            s += longint'(cur_a[i]) * longint'(cur_b[i]);
            if (i > 0) e.bub += cur_gap[i];
        end
        if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
        if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
        e.data = s[39:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.len = cur_a.size();
        sb.push_back(e);
        cmd_len = LEN_W'(cur_a.size());
        cmd_sat = sat;
        cmd_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
        end
        if (!got) abort_run("cmd_accept_timeout");
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed_ops(input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            op_valid = 1'b0;
            repeat (cur_gap[i]) begin @(posedge clk); #1; end
            op_valid = 1'b1;
            op_a = 16'(cur_a[i]);
            op_b = 16'(cur_b[i]);
            got = 0;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                if (op_ready) got = 1;
            end
            if (!got) abort_run("op_accept_timeout");
            @(posedge clk); #1;
            op_valid = 1'b0;
            op_a = 16'h0000;
            op_b = 16'h0000;
        end
    endtask

    task automatic take_result(input int delay);
        bit got;
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (res_valid) got = 1;
        end
        if (!got) abort_run("res_valid_timeout");
        repeat (delay + 1) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        hs_edge = cyc + 1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_len = '0; cmd_sat = 1'b0;
        op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_instr", 64'(mac_instruction), 64'd0);
        check("rst_stall", 64'(mac_stall), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Three pairs back-to-back, then with two bubbles between pairs 1 and 2.
        cur_a = '{2, 4, -6}; cur_b = '{3, 5, 7}; cur_gap = '{0, 0, 0};
        issue_cmd(1'b0); feed_ops(3); take_result(0);
        cur_gap = '{0, 2, 0};
        issue_cmd(1'b0); feed_ops(3); take_result(1);

        // Guard-bit overflow, unsaturated then saturated.
        cur_a = '{-32768, -32768, -32768, -32768}; cur_b = cur_a; cur_gap = '{0, 0, 0, 0};
        issue_cmd(1'b0); feed_ops(4); take_result(0);
        issue_cmd(1'b1); feed_ops(4); take_result(0);

        // Zero length.
        cur_a.delete(); cur_b.delete(); cur_gap.delete();
        issue_cmd(1'b0); feed_ops(0); take_result(0);

        // Backpressure with a second command pending.
        cur_a = '{2, 4, -6}; cur_b = '{3, 5, 7}; cur_gap = '{0, 0, 0};
        issue_cmd(1'b0); feed_ops(3);
        prep_random(2);
        fork
            take_result(5);
            issue_cmd(1'b0);
        join
        check("next_cmd_accept_edge", 64'(acc_edge), 64'(hs_edge + 1));
        feed_ops(2); take_result(0);

        // Reset mid-run after two of five pairs.
        prep_random(5);
        for (int i = 0; i < 5; i++) cur_gap[i] = 0;
        issue_cmd(1'b0); feed_ops(2);
        #1 reset_n = 1'b0;
        #1;
        check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("arst_op_ready", 64'(op_ready), 64'd0);
        check("arst_instr", 64'(mac_instruction), 64'd0);
        check("arst_operands", {mac_multiplier, mac_multiplicand}, 64'd0);
        check("arst_stall", 64'(mac_stall), 64'd0);
        check("arst_res", {res_valid, res_ovf, res_data}, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_no_result", {res_valid, busy}, 64'd0);
        end
        @(posedge clk); #1;
        cur_a = '{3}; cur_b = '{3}; cur_gap = '{0};
        issue_cmd(1'b0); feed_ops(1); take_result(0);

        // Random commands.
        for (int t = 0; t < 25; t++) begin
            prep_random($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 5)));
            issue_cmd($urandom_range(0, 1) == 1);
            feed_ops(cur_a.size());
            take_result($urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        finish_run();
    end

endmodule
